// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writeback
// sources, with a registered write stage and combinational bypass for two read ports.
module regfile_wport_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      stall_in,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic [ADDR_W-1:0]         chk_addr_1,
  input  logic [ADDR_W-1:0]         chk_addr_2,
  output logic                      chk_hit_1,
  output logic                      chk_hit_2,
  output logic [DATA_W-1:0]         chk_data_1,
  output logic [DATA_W-1:0]         chk_data_2
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   ptr_reg;
  logic [PTR_W-1:0]   ptr_next;
  logic               we_reg;
  logic [ADDR_W-1:0]  waddr_reg;
  logic [DATA_W-1:0]  wdata_reg;

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [PTR_W-1:0]   hi_idx;
  logic [PTR_W-1:0]   lo_idx;
  logic [PTR_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [DATA_W-1:0]  gnt_data;
  logic               any_valid;
  logic               transfer;

  // Requesters at or above ptr get first pick; otherwise wrap to the lowest index.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign mask[gi]   = (PTR_W'(gi) >= ptr_reg);
      assign gnt_oh[gi] = any_valid && (gnt_idx == PTR_W'(gi));
    end
  endgenerate

  assign masked    = req_valid & mask;
  assign any_valid = |req_valid;

  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (masked[i])    hi_idx = PTR_W'(i);
      if (req_valid[i]) lo_idx = PTR_W'(i);
    end
  end

  assign gnt_idx = (|masked) ? hi_idx : lo_idx;

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
        gnt_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign transfer  = any_valid && !stall_in && reset;
  assign req_ready = (stall_in || !reset) ? '0 : gnt_oh;
  assign ptr_next  = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);

  // Writes to x0 are consumed but never raise the write enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg   <= '0;
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      we_reg <= transfer && (gnt_addr != '0);
      if (transfer) begin
        ptr_reg   <= ptr_next;
        waddr_reg <= gnt_addr;
        wdata_reg <= gnt_data;
      end
    end
  end

  assign rf_we    = we_reg;
  assign rf_waddr = waddr_reg;
  assign rf_wdata = wdata_reg;

  assign chk_hit_1  = we_reg && (waddr_reg == chk_addr_1) && (chk_addr_1 != '0);
  assign chk_hit_2  = we_reg && (waddr_reg == chk_addr_2) && (chk_addr_2 != '0);
  assign chk_data_1 = chk_hit_1 ? wdata_reg : '0;
  assign chk_data_2 = chk_hit_2 ? wdata_reg : '0;

  // A request left waiting last cycle must still be valid now.
  logic [NUM_REQ-1:0] pend_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_reg <= '0;
    else        pend_reg <= req_valid & ~req_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert ((pend_reg & ~req_valid) == '0)
        else $error("request valid dropped before transfer");
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: table of per-cycle vectors plus
// hand-written sequences for reset, continuous round-robin and mid-write reset.
module tb_regfile_wport_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        stall_in;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  chk_addr_1;
  logic [4:0]  chk_addr_2;
  logic        chk_hit_1;
  logic        chk_hit_2;
  logic [31:0] chk_data_1;
  logic [31:0] chk_data_2;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wport_arbiter #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .stall_in(stall_in),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2),
    .chk_hit_1(chk_hit_1), .chk_hit_2(chk_hit_2),
    .chk_data_1(chk_data_1), .chk_data_2(chk_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  valid;
    logic        stall;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [4:0]  c1, c2;
    logic [2:0]  exp_ready;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_hit1;
    logic [31:0] exp_d1;
    logic        exp_hit2;
    logic [31:0] exp_d2;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [2:0] valid, input logic stall,
                     input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                     input logic [4:0] c1, input logic [4:0] c2,
                     input logic [2:0] er, input logic ewe, input logic [4:0] ewa,
                     input logic [31:0] ewd, input logic eh1, input logic [31:0] ed1,
                     input logic eh2, input logic [31:0] ed2);
    vec_t v;
    v.valid = valid; v.stall = stall;
    v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.c1 = c1; v.c2 = c2;
    v.exp_ready = er; v.exp_we = ewe; v.exp_waddr = ewa; v.exp_wdata = ewd;
    v.exp_hit1 = eh1; v.exp_d1 = ed1; v.exp_hit2 = eh2; v.exp_d2 = ed2;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] valid, input logic stall,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    req_valid = valid;
    stall_in  = stall;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
  endtask

  initial begin
    reset = 1'b0;
    drive(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    chk_addr_1 = '0;
    chk_addr_2 = '0;

    //    valid  st  a0  a1  a2  d0            d1            d2            c1  c2  rdy    we wa  wd            h1 d1            h2 d2
    add(3'b001, 0,  5,  0,  0, 32'hDEADBEEF, 32'h0,        32'h0,         5,  0, 3'b001, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    add(3'b000, 0,  0,  0,  0, 32'h0,        32'h0,        32'h0,         5,  7, 3'b000, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 32'h0);
    add(3'b000, 0,  0,  0,  0, 32'h0,        32'h0,        32'h0,         5,  0, 3'b000, 0, 5, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
    add(3'b010, 0,  0,  3,  0, 32'h0,        32'h11111111, 32'h0,         3,  0, 3'b010, 0, 5, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
    add(3'b110, 0,  0,  7,  9, 32'h0,        32'h22222222, 32'h33333333,  3,  9, 3'b100, 1, 3, 32'h11111111, 1, 32'h11111111, 0, 32'h0);
    add(3'b010, 0,  0,  7,  9, 32'h0,        32'h22222222, 32'h33333333,  9,  9, 3'b010, 1, 9, 32'h33333333, 1, 32'h33333333, 1, 32'h33333333);
    add(3'b001, 0,  0,  0,  0, 32'h00001234, 32'h0,        32'h0,         7,  0, 3'b001, 1, 7, 32'h22222222, 1, 32'h22222222, 0, 32'h0);
    add(3'b000, 0,  0,  0,  0, 32'h0,        32'h0,        32'h0,         0,  7, 3'b000, 0, 0, 32'h00001234, 0, 32'h0,        0, 32'h0);
    add(3'b011, 0,  2,  4,  0, 32'h44444444, 32'h55555555, 32'h0,         0,  0, 3'b010, 0, 0, 32'h00001234, 0, 32'h0,        0, 32'h0);
    add(3'b001, 1,  2,  4,  0, 32'h44444444, 32'h55555555, 32'h0,         4,  2, 3'b000, 1, 4, 32'h55555555, 1, 32'h55555555, 0, 32'h0);
    add(3'b001, 1,  2,  4,  0, 32'h44444444, 32'h55555555, 32'h0,         4,  2, 3'b000, 0, 4, 32'h55555555, 0, 32'h0,        0, 32'h0);
    add(3'b001, 1,  2,  4,  0, 32'h44444444, 32'h55555555, 32'h0,         4,  2, 3'b000, 0, 4, 32'h55555555, 0, 32'h0,        0, 32'h0);
    add(3'b101, 0,  2,  0,  6, 32'h44444444, 32'h0,        32'h66666666,  4,  2, 3'b100, 0, 4, 32'h55555555, 0, 32'h0,        0, 32'h0);
    add(3'b001, 0,  2,  0,  6, 32'h44444444, 32'h0,        32'h66666666,  6,  6, 3'b001, 1, 6, 32'h66666666, 1, 32'h66666666, 1, 32'h66666666);
    add(3'b000, 0,  0,  0,  0, 32'h0,        32'h0,        32'h0,         2,  1, 3'b000, 1, 2, 32'h44444444, 1, 32'h44444444, 0, 32'h0);

    // Reset state, with a request pending that must not see ready.
    @(negedge clk);
    req_valid = 3'b001;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_we",    32'(rf_we),     32'h0);
    chk("rst_waddr", 32'(rf_waddr),  32'h0);
    chk("rst_wdata", rf_wdata,       32'h0);
    req_valid = 3'b000;
    @(negedge clk);
    reset = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].valid, vq[i].stall, vq[i].a0, vq[i].a1, vq[i].a2,
            vq[i].d0, vq[i].d1, vq[i].d2);
      chk_addr_1 = vq[i].c1;
      chk_addr_2 = vq[i].c2;
      #1;
      $display("vec %0d: valid=%b stall=%b ready=%b we=%b waddr=%0d wdata=%08h hit1=%b hit2=%b",
               i, req_valid, stall_in, req_ready, rf_we, rf_waddr, rf_wdata, chk_hit_1, chk_hit_2);
      chk($sformatf("v%0d_ready", i), 32'(req_ready),  32'(vq[i].exp_ready));
      chk($sformatf("v%0d_we", i),    32'(rf_we),      32'(vq[i].exp_we));
      chk($sformatf("v%0d_waddr", i), 32'(rf_waddr),   32'(vq[i].exp_waddr));
      chk($sformatf("v%0d_wdata", i), rf_wdata,        vq[i].exp_wdata);
      chk($sformatf("v%0d_hit1", i),  32'(chk_hit_1),  32'(vq[i].exp_hit1));
      chk($sformatf("v%0d_data1", i), chk_data_1,      vq[i].exp_d1);
      chk($sformatf("v%0d_hit2", i),  32'(chk_hit_2),  32'(vq[i].exp_hit2));
      chk($sformatf("v%0d_data2", i), chk_data_2,      vq[i].exp_d2);
      @(negedge clk);
    end

    // All three requesters valid continuously from a fresh reset.
    reset = 1'b0;
    drive(3'b111, 1'b0, 5'd10, 5'd11, 5'd12, 32'hA0, 32'hA1, 32'hA2);
    chk_addr_1 = '0;
    chk_addr_2 = '0;
    #1;
    chk("rr_rst_ready", 32'(req_ready), 32'h0);
    chk("rr_rst_we",    32'(rf_we),     32'h0);
    chk("rr_rst_waddr", 32'(rf_waddr),  32'h0);
    chk("rr_rst_wdata", rf_wdata,       32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 7; c++) begin
      int g;
      int pg;
      g  = c % 3;
      pg = (c + 2) % 3;
      #1;
      $display("rr cycle %0d: ready=%b we=%b waddr=%0d wdata=%08h", c, req_ready, rf_we, rf_waddr, rf_wdata);
      chk($sformatf("rr%0d_ready", c), 32'(req_ready), 32'(1) << g);
      if (c == 0) begin
        chk("rr0_we", 32'(rf_we), 32'h0);
      end else begin
        chk($sformatf("rr%0d_we", c),    32'(rf_we),    32'h1);
        chk($sformatf("rr%0d_waddr", c), 32'(rf_waddr), 32'(10 + pg));
        chk($sformatf("rr%0d_wdata", c), rf_wdata,      32'(32'hA0 + pg));
      end
      @(negedge clk);
    end

    // Reset asserted while a write is in flight: rf_we must drop at once.
    #1;
    chk("mid_we_before", 32'(rf_we),    32'h1);
    chk("mid_waddr_before", 32'(rf_waddr), 32'd10);
    #2;
    reset = 1'b0;
    req_valid = 3'b000;
    #1;
    $display("mid-write reset: we=%b waddr=%0d wdata=%08h ready=%b", rf_we, rf_waddr, rf_wdata, req_ready);
    chk("mid_we_async",    32'(rf_we),     32'h0);
    chk("mid_waddr_async", 32'(rf_waddr),  32'h0);
    chk("mid_wdata_async", rf_wdata,       32'h0);
    chk("mid_ready_async", 32'(req_ready), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_we0", 32'(rf_we), 32'h0);
    @(negedge clk);
    #1;
    chk("post_rst_we1", 32'(rf_we), 32'h0);
    // ptr was 1 before reset; after reset it must be 0, so req0 beats req2.
    drive(3'b101, 1'b0, 5'd10, 5'd11, 5'd12, 32'hA0, 32'hA1, 32'hA2);
    #1;
    $display("post-reset grant: ready=%b", req_ready);
    chk("post_rst_ready0", 32'(req_ready), 32'b001);
    @(negedge clk);
    #1;
    chk("post_rst_ready1", 32'(req_ready), 32'b100);
    chk("post_rst_we2",    32'(rf_we),     32'h1);
    chk("post_rst_waddr2", 32'(rf_waddr),  32'd10);
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    chk("post_rst_we3",    32'(rf_we),    32'h1);
    chk("post_rst_waddr3", 32'(rf_waddr), 32'd12);
    chk("post_rst_wdata3", rf_wdata,      32'hA2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
